cpu_mem_arbiter: RTL and testbench

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

---
 rtl/cpu_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//   Arbitrates a single 64-bit memory port between an instruction-fetch
//   requester (I side) and a load/store requester (D side). Exactly one access
//   is in flight at a time. Each access goes IDLE -> IBUSY/DBUSY -> DONE -> IDLE.
//
// Parameters
//   RR_ENABLE : 1 = round-robin on ties, 0 = D side always wins ties
//
// Ports
//   clk, rst_n                : clock (rising edge), async active-low reset
//   ibus_read/address         : I-side fetch request and address
//   ibus_stall/rddata         : I-side wait and read data
//   dbus_read/write/address   : D-side request and address
//   dbus_byteenable/wrdata    : D-side write lanes and data
//   dbus_stall/rddata         : D-side wait and read data
//   mem_req/we/addr/be/wdata  : registered memory request, held until ack
//   mem_ack/rdata             : one-cycle completion pulse and read data
module cpu_mem_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ibus_read,
    input  logic [31:0] ibus_address,
    output logic        ibus_stall,
    output logic [63:0] ibus_rddata,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_address,
    input  logic [7:0]  dbus_byteenable,
    input  logic [63:0] dbus_wrdata,
    output logic        dbus_stall,
    output logic [63:0] dbus_rddata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_gnt_d;    // side owning the current access: 0 = I, 1 = D
    logic        r_last_d;   // side granted most recently (round-robin pointer)
    logic        r_idone;
    logic        r_ddone;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [7:0]  r_mem_be;
    logic [63:0] r_mem_wdata;
    logic [63:0] r_ibus_rddata;
    logic [63:0] r_dbus_rddata;

    logic        w_ireq;
    logic        w_dreq;
    logic        w_pick_d;
    logic        w_grant;
    logic        w_complete;

    always_comb begin
        w_ireq = ibus_read;
        w_dreq = dbus_read | dbus_write;
        if (w_ireq && w_dreq) begin
            w_pick_d = (RR_ENABLE == 0) ? 1'b1 : ~r_last_d;
        end else begin
            w_pick_d = w_dreq;
        end
        w_grant    = (r_state == IDLE) && (w_ireq || w_dreq);
        w_complete = ((r_state == IBUSY) || (r_state == DBUSY)) && mem_ack;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_ireq || w_dreq) w_next = w_pick_d ? DBUSY : IBUSY;
            IBUSY,
            DBUSY:   if (mem_ack) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_d       <= 1'b0;
            r_last_d      <= 1'b0;
            r_idone       <= 1'b0;
            r_ddone       <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_be      <= '0;
            r_mem_wdata   <= '0;
            r_ibus_rddata <= '0;
            r_dbus_rddata <= '0;
        end else begin
            // Done flags are set on the completing edge, so they are high
            // exactly during the single DONE cycle.
            r_idone <= 1'b0;
            r_ddone <= 1'b0;
            if (w_grant) begin
                r_mem_req <= 1'b1;
                r_gnt_d   <= w_pick_d;
                r_last_d  <= w_pick_d;
                if (w_pick_d) begin
                    r_mem_addr <= dbus_address & ~32'h7;
                end else begin
                    r_mem_addr <= ibus_address & ~32'h7;
                end
                // A simultaneous read+write on the D side is issued as a write.
                if (w_pick_d && dbus_write) begin
                    r_mem_we    <= 1'b1;
                    r_mem_be    <= dbus_byteenable;
                    r_mem_wdata <= dbus_wrdata;
                end else begin
                    r_mem_we <= 1'b0;
                    r_mem_be <= 8'hFF;
                end
            end
            if (w_complete) begin
                r_mem_req <= 1'b0;
                r_idone   <= ~r_gnt_d;
                r_ddone   <= r_gnt_d;
                if (!r_gnt_d) begin
                    r_ibus_rddata <= mem_rdata;
                end else if (!r_mem_we) begin
                    r_dbus_rddata <= mem_rdata;
                end
            end
        end
    end

    // The done flags are equivalent to (state == DONE && granted side).
    assign ibus_stall  = ibus_read & ~r_idone;
    assign dbus_stall  = (dbus_read | dbus_write) & ~r_ddone;
    assign ibus_rddata = r_ibus_rddata;
    assign dbus_rddata = r_dbus_rddata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_be      = r_mem_be;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter
//   Directed bench for cpu_mem_arbiter. Two instances share the requester
//   inputs: u_dut (round-robin) and u_fp (fixed D priority). Expected memory
//   transactions are queued when a request is driven and compared when the
//   DUT raises mem_req.
module tb_cpu_mem_arbiter;

    typedef struct packed {
        logic        side_d;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_address;
    logic [7:0]  dbus_byteenable;
    logic [63:0] dbus_wrdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_ack_fp;
    logic [63:0] mem_rdata_fp;

    logic        ibus_stall, dbus_stall, mem_req, mem_we;
    logic [63:0] ibus_rddata, dbus_rddata, mem_wdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;

    logic        fp_ibus_stall, fp_dbus_stall, fp_mem_req, fp_mem_we;
    logic [63:0] fp_ibus_rddata, fp_dbus_rddata, fp_mem_wdata;
    logic [31:0] fp_mem_addr;
    logic [7:0]  fp_mem_be;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    exp_t q_fp[$];
    logic [63:0] exp_irdata;
    logic [63:0] exp_drdata;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.RR_ENABLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_read(ibus_read), .ibus_address(ibus_address),
        .ibus_stall(ibus_stall), .ibus_rddata(ibus_rddata),
        .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_address(dbus_address), .dbus_byteenable(dbus_byteenable),
        .dbus_wrdata(dbus_wrdata), .dbus_stall(dbus_stall),
        .dbus_rddata(dbus_rddata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    cpu_mem_arbiter #(.RR_ENABLE(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .ibus_read(ibus_read), .ibus_address(ibus_address),
        .ibus_stall(fp_ibus_stall), .ibus_rddata(fp_ibus_rddata),
        .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_address(dbus_address), .dbus_byteenable(dbus_byteenable),
        .dbus_wrdata(dbus_wrdata), .dbus_stall(fp_dbus_stall),
        .dbus_rddata(fp_dbus_rddata),
        .mem_req(fp_mem_req), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
        .mem_be(fp_mem_be), .mem_wdata(fp_mem_wdata),
        .mem_ack(mem_ack_fp), .mem_rdata(mem_rdata_fp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_underflow(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    endtask

    // Wait for mem_req, compare against the scoreboard head, hold for
    // 'delay' cycles checking stability, ack, then check the DONE cycle.
    task automatic serve(input logic [63:0] rdata, input int delay,
                         input int exp_wait, input bit perturb);
        int   cnt = 0;
        exp_t e;
        while (!mem_req && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("req_wait", 64'(cnt), 64'(exp_wait));
        if (q.size() == 0) begin
            sb_underflow("sb");
            return;
        end
        e = q.pop_front();
        chk("mem_req", 64'(mem_req), 64'(1'b1));
        chk("mem_we", 64'(mem_we), 64'(e.we));
        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        chk("mem_be", 64'(mem_be), 64'(e.be));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        if (e.side_d) chk("dstall_busy", 64'(dbus_stall), 64'(1'b1));
        else          chk("istall_busy", 64'(ibus_stall), 64'(1'b1));
        if (perturb) begin
            dbus_address    = 32'hFFFF_FFF8;
            dbus_wrdata     = '1;
            dbus_byteenable = 8'hAA;
            dbus_write      = 1'b0;
        end
        repeat (delay) begin
            tick();
            chk("hold_req", 64'(mem_req), 64'(1'b1));
            chk("hold_addr", 64'(mem_addr), 64'(e.addr));
            chk("hold_we", 64'(mem_we), 64'(e.we));
            chk("hold_be", 64'(mem_be), 64'(e.be));
            if (e.we) chk("hold_wdata", mem_wdata, e.wdata);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = {$urandom, $urandom};
        if (!e.side_d)  exp_irdata = rdata;
        else if (!e.we) exp_drdata = rdata;
        chk("req_after_ack", 64'(mem_req), 64'(1'b0));
        chk("ibus_rddata", ibus_rddata, exp_irdata);
        chk("dbus_rddata", dbus_rddata, exp_drdata);
        if (e.side_d) chk("dstall_done", 64'(dbus_stall), 64'(1'b0));
        else          chk("istall_done", 64'(ibus_stall), 64'(1'b0));
    endtask

    initial begin
        exp_t e;
        int   cnt;

        rst_n = 1'b0;
        ibus_read = 1'b0; ibus_address = '0;
        dbus_read = 1'b0; dbus_write = 1'b0; dbus_address = '0;
        dbus_byteenable = '0; dbus_wrdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; mem_ack_fp = 1'b0; mem_rdata_fp = '0;
        exp_irdata = '0; exp_drdata = '0;

        // Reset state
        #1;
        chk("rst_req", 64'(mem_req), 64'(1'b0));
        chk("rst_we", 64'(mem_we), 64'(1'b0));
        chk("rst_addr", 64'(mem_addr), 64'h0);
        chk("rst_be", 64'(mem_be), 64'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        chk("rst_irdata", ibus_rddata, 64'h0);
        chk("rst_drdata", dbus_rddata, 64'h0);
        ibus_read = 1'b1;
        dbus_write = 1'b1;
        #1;
        chk("rst_istall", 64'(ibus_stall), 64'(1'b1));
        chk("rst_dstall", 64'(dbus_stall), 64'(1'b1));
        tick();
        chk("rst_held_req", 64'(mem_req), 64'(1'b0));
        ibus_read = 1'b0;
        dbus_write = 1'b0;
        rst_n = 1'b1;
        tick();

        // I fetch, minimum latency
        ibus_address = 32'h1FC0_0004;
        ibus_read = 1'b1;
        q.push_back('{1'b0, 1'b0, 32'h1FC0_0000, 8'hFF, 64'h0});
        serve(64'h1122_3344_5566_7788, 0, 1, 1'b0);
        ibus_read = 1'b0;
        tick();
        chk("idle_istall", 64'(ibus_stall), 64'(1'b0));
        chk("idle_req", 64'(mem_req), 64'(1'b0));

        // D write with inputs perturbed and request dropped while in flight
        dbus_address = 32'h8000_0010;
        dbus_byteenable = 8'h0F;
        dbus_wrdata = 64'h0000_0000_DEAD_BEEF;
        dbus_write = 1'b1;
        q.push_back('{1'b1, 1'b1, 32'h8000_0010, 8'h0F, 64'h0000_0000_DEAD_BEEF});
        serve(64'hCAFE_CAFE_CAFE_CAFE, 3, 1, 1'b1);
        tick();
        chk("wr_done_idle", 64'(mem_req), 64'(1'b0));

        // Spurious ack in IDLE
        mem_ack = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        chk("spur_req", 64'(mem_req), 64'(1'b0));
        chk("spur_irdata", ibus_rddata, exp_irdata);
        chk("spur_drdata", dbus_rddata, exp_drdata);
        tick();
        chk("spur_req2", 64'(mem_req), 64'(1'b0));

        // Round-robin tie after reset: D, I, D, I
        rst_n = 1'b0;
        #1;
        exp_irdata = '0; exp_drdata = '0;
        tick();
        rst_n = 1'b1;
        tick();
        ibus_address = 32'h0000_1008;
        dbus_address = 32'h0000_2017;
        ibus_read = 1'b1;
        dbus_read = 1'b1;
        for (int unsigned k = 0; k < 2; k++) begin
            q.push_back('{1'b1, 1'b0, 32'h0000_2010, 8'hFF, 64'h0});
            q.push_back('{1'b0, 1'b0, 32'h0000_1008, 8'hFF, 64'h0});
        end
        for (int unsigned k = 0; k < 4; k++) begin
            serve(64'hA000_0000_0000_0000 + 64'(k), 0, (k == 0) ? 1 : 2, 1'b0);
            if (k[0]) chk("rr_dstall_held", 64'(dbus_stall), 64'(1'b1));
            else      chk("rr_istall_held", 64'(ibus_stall), 64'(1'b1));
        end
        ibus_read = 1'b0;
        dbus_read = 1'b0;
        tick();

        // Reset mid-access
        ibus_address = 32'h0000_0100;
        ibus_read = 1'b1;
        tick();
        chk("mid_req", 64'(mem_req), 64'(1'b1));
        chk("mid_addr", 64'(mem_addr), 64'h100);
        rst_n = 1'b0;
        #1;
        exp_irdata = '0; exp_drdata = '0;
        chk("mid_rst_req", 64'(mem_req), 64'(1'b0));
        chk("mid_rst_addr", 64'(mem_addr), 64'h0);
        chk("mid_rst_istall", 64'(ibus_stall), 64'(1'b1));
        ibus_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        mem_rdata = 64'h5555_AAAA_5555_AAAA;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_req", 64'(mem_req), 64'(1'b0));
        chk("late_ack_irdata", ibus_rddata, 64'h0);
        dbus_address = 32'h0000_2008;
        dbus_read = 1'b1;
        q.push_back('{1'b1, 1'b0, 32'h0000_2008, 8'hFF, 64'h0});
        serve(64'h0F0F_0F0F_1234_5678, 1, 1, 1'b0);
        dbus_read = 1'b0;
        tick();

        // Fixed priority on u_fp: D (read+write -> write) wins every tie
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
        ibus_address = 32'h0000_3000;
        dbus_address = 32'h4000_0018;
        dbus_byteenable = 8'h3C;
        dbus_wrdata = 64'h0123_4567_89AB_CDEF;
        ibus_read = 1'b1;
        dbus_read = 1'b1;
        dbus_write = 1'b1;
        repeat (4) q_fp.push_back('{1'b1, 1'b1, 32'h4000_0018, 8'h3C, 64'h0123_4567_89AB_CDEF});
        q_fp.push_back('{1'b0, 1'b0, 32'h0000_3000, 8'hFF, 64'h0});
        for (int unsigned k = 0; k < 5; k++) begin
            cnt = 0;
            while (!fp_mem_req && cnt < 20) begin
                tick();
                cnt++;
            end
            chk("fp_wait", 64'(cnt), (k == 0) ? 64'd1 : 64'd2);
            if (q_fp.size() == 0) begin
                sb_underflow("fp_sb");
            end else begin
                e = q_fp.pop_front();
                chk("fp_we", 64'(fp_mem_we), 64'(e.we));
                chk("fp_addr", 64'(fp_mem_addr), 64'(e.addr));
                chk("fp_be", 64'(fp_mem_be), 64'(e.be));
                if (e.we) chk("fp_wdata", fp_mem_wdata, e.wdata);
            end
            mem_ack_fp = 1'b1;
            mem_rdata_fp = 64'h7777_0000_0000_0000 + 64'(k);
            tick();
            mem_ack_fp = 1'b0;
            if (k < 4) begin
                chk("fp_dstall_done", 64'(fp_dbus_stall), 64'(1'b0));
                chk("fp_istall_held", 64'(fp_ibus_stall), 64'(1'b1));
                chk("fp_drdata", fp_dbus_rddata, 64'h0);
                if (k == 3) begin
                    dbus_read = 1'b0;
                    dbus_write = 1'b0;
                end
            end else begin
                chk("fp_istall_done", 64'(fp_ibus_stall), 64'(1'b0));
                chk("fp_irdata", fp_ibus_rddata, 64'h7777_0000_0000_0004);
            end
        end
        ibus_read = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
